gb_interrupt_ctrl: RTL and testbench
====================================

// Module: gb_interrupt_ctrl
// PURPOSE
// - Responder side of the CPU interrupt interface: owns IF (0xFF0F) and IE (0xFFFF), drives
//   reg_IF/reg_IE into the CPU, services clear_interrupt_flag, answers CPU bus reads/writes.
// - Sits beside the CPU on the M-cycle clock. Latches peripheral requests (VBlank, STAT, Timer,
//   Serial, Joypad) as rising edges into IF.
// PARAMETERS
// - IF_ADDR   16'hFF0F  bus address of IF
// - IE_ADDR   16'hFFFF  bus address of IE
// - NUM_IRQ   5         number of request lines / implemented IF bits (fixed 5 for DMG)
// PORTS
// - clk                   in   1   M-cycle clock
// - reset_n               in   1   asynchronous, active-low reset
// - addr_i                in   16  CPU address bus (CPU addr_o)
// - data_i                in   8   CPU write data (CPU data_o)
// - wr_en_i               in   1   CPU write strobe (CPU drive_data_bus)
// - clear_interrupt_flag  in   1   CPU request: clear highest-priority pending bit
// - irq_i                 in   5   level requests; bit0 VBlank .. bit4 Joypad
// - reg_IF                out  8   {3'b000, IF[4:0]} to CPU
// - reg_IE                out  8   IE[7:0] to CPU
// - rdata_o               out  8   read data for the bus mux
// - rdata_hit_o           out  1   addr_i matches IF_ADDR or IE_ADDR and ~wr_en_i
// BEHAVIOUR
// - Reset (async, reset_n=0): IF=0, IE=0, irq_prev=0, sync flops=0. Outputs: reg_IF=0, reg_IE=0,
//   rdata_o=0 unless addr hits (comb), rdata_hit_o comb.
// - Edge detect: rise = irq_s & ~irq_prev; irq_prev <= irq_s each clk. irq_s = irq_i
//   (or synced copy, see CONFIGURATION). Level held high sets IF once only.
// - Latency: irq_i 0->1 before edge N -> IF bit visible on reg_IF after edge N (1 cycle).
// - clear_interrupt_flag: pend = IF & IE[4:0]; clears lowest-index set bit of pend
//   (bit0 highest priority). pend==0 -> no change.
// - CPU write, wr_en_i=1: addr_i==IF_ADDR -> IF <= data_i[4:0] (data_i[7:5] dropped);
//   addr_i==IE_ADDR -> IE <= data_i (all 8 bits stored).
// - Per-bit IF next-state priority in one cycle: rise[k] sets > CPU IF write > clear. A bit
//   rising while cleared or written 0 ends set. Clear chooses its bit from pre-edge IF/IE.
//   It never touches other bits.
// - IE write and clear same cycle: clear uses old IE.
// - Reads, comb, wr_en_i=0:
//   - IF_ADDR -> rdata_o = {3'b111, IF}.
//   - IE_ADDR -> rdata_o = IE.
//   - Else rdata_o = 8'h00, rdata_hit_o = 0.
// - reg_IF upper bits forced 0 so (reg_IF & reg_IE) != 0 only for real requests.
//   reg_IE passes IE[7:5] unmodified.
// - Write with no address match: ignored.
// - reset_n asserted mid-cycle clears all state immediately. Pending edges are lost.
//   After release, any irq_i already high is counted as a rise on the first clk.
// CONFIGURATION
// - GB_IRQ_SYNC_EN defined: irq_i passes through a 2-flop synchronizer per bit (reset 0)
//   before edge detect.
//   - irq_i->IF latency becomes 3 cycles.
//   - Pulses shorter than 1 clk are not guaranteed captured.
// - Undefined: irq_i used directly (1-cycle latency). irq_i must be synchronous to clk.
// TESTING
// - Reset: reset_n=0 with irq_i=5'h1F -> reg_IF=0, reg_IE=0. Read FF0F -> rdata_o=8'hE0.
// - Edge: irq_i[2] 0->1, held 10 cycles -> IF=5'h04 after 1 cycle (3 with GB_IRQ_SYNC_EN).
//   Write FF0F=00 while held -> IF stays 0. No re-set until irq_i[2] drops and rises again.
// - Priority clear: IF=5'h1A, IE=8'h18, pulse clear_interrupt_flag -> IF=5'h12.
//   Pulse again -> IF=5'h02. Pulse again with pend=0 -> IF=5'h02 unchanged.
// - Collision: IF=5'h01, IE=8'h01; same cycle clear=1 and irq_i[0] rises -> IF=5'h01.
//   Same cycle write FF0F=8'h00 and irq_i[3] rises -> IF=5'h08.
// - Bus: write FFFF=8'hFF -> reg_IE=8'hFF, read FFFF=8'hFF. Write FF0F=8'hFF -> reg_IF=8'h1F,
//   read FF0F=8'hFF. Read FF10 -> rdata_hit_o=0, rdata_o=8'h00.
// - Async reset mid-run: IF=5'h1F, IE=8'h1F, assert reset_n between edges -> outputs 0 at once.

Source files
------------

// File: rtl/gb_interrupt_ctrl.sv
// Interrupt controller owning IF (FF0F) and IE (FFFF): latches peripheral request edges,
// services CPU clear requests and bus accesses. Define GB_IRQ_SYNC_EN to add 2-flop input sync.
module gb_interrupt_ctrl #(
   parameter logic [15:0] IF_ADDR = 16'hFF0F,
   parameter logic [15:0] IE_ADDR = 16'hFFFF,
   parameter int          NUM_IRQ = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [15:0]        addr_i,
   input  logic [7:0]         data_i,
   input  logic               wr_en_i,
   input  logic               clear_interrupt_flag,
   input  logic [NUM_IRQ-1:0] irq_i,
   output logic [7:0]         reg_IF,
   output logic [7:0]         reg_IE,
   output logic [7:0]         rdata_o,
   output logic               rdata_hit_o
);

   logic [NUM_IRQ-1:0] if_q;
   logic [7:0]         ie_q;
   logic [NUM_IRQ-1:0] irq_s;
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] clr_mask;
   logic [NUM_IRQ-1:0] if_nxt;
   logic               wr_if;
   logic               wr_ie;

`ifdef GB_IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] irq_sync1;
   logic [NUM_IRQ-1:0] irq_sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_sync1 <= '0;
         irq_sync2 <= '0;
      end else begin
         irq_sync1 <= irq_i;
         irq_sync2 <= irq_sync1;
      end
   end

   assign irq_s = irq_sync2;
`else
   assign irq_s = irq_i;
`endif

   assign rise  = irq_s & ~irq_prev;
   assign wr_if = wr_en_i && (addr_i == IF_ADDR);
   assign wr_ie = wr_en_i && (addr_i == IE_ADDR);

   // Clear picks from pre-edge IF/IE; isolating the lowest set bit gives bit0 top priority.
   assign pend     = if_q & ie_q[NUM_IRQ-1:0];
   assign clr_mask = pend & (~pend + NUM_IRQ'(1));

   always_comb begin
      if_nxt = if_q;
      if (clear_interrupt_flag) if_nxt = if_nxt & ~clr_mask;
      if (wr_if)                if_nxt = data_i[NUM_IRQ-1:0];
      if_nxt = if_nxt | rise;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         if_q     <= '0;
         ie_q     <= '0;
         irq_prev <= '0;
      end else begin
         if_q     <= if_nxt;
         irq_prev <= irq_s;
         if (wr_ie) ie_q <= data_i;
      end
   end

   // Upper IF bits forced low so reg_IF & reg_IE only flags real requests.
   assign reg_IF = {{(8-NUM_IRQ){1'b0}}, if_q};
   assign reg_IE = ie_q;

   always_comb begin
      rdata_o     = 8'h00;
      rdata_hit_o = 1'b0;
      if (!wr_en_i) begin
         if (addr_i == IF_ADDR) begin
            rdata_o     = {{(8-NUM_IRQ){1'b1}}, if_q};
            rdata_hit_o = 1'b1;
         end else if (addr_i == IE_ADDR) begin
            rdata_o     = ie_q;
            rdata_hit_o = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// Directed bench for gb_interrupt_ctrl; expectations queued at drive time, popped at check time.
// Honours GB_IRQ_SYNC_EN for the irq_i -> IF latency.
module tb_gb_interrupt_ctrl;

`ifdef GB_IRQ_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        reset_n;
   logic [15:0] addr_i;
   logic [7:0]  data_i;
   logic        wr_en_i;
   logic        clear_interrupt_flag;
   logic [4:0]  irq_i;
   logic [7:0]  reg_IF;
   logic [7:0]  reg_IE;
   logic [7:0]  rdata_o;
   logic        rdata_hit_o;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   gb_interrupt_ctrl dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .addr_i               (addr_i),
      .data_i               (data_i),
      .wr_en_i              (wr_en_i),
      .clear_interrupt_flag (clear_interrupt_flag),
      .irq_i                (irq_i),
      .reg_IF               (reg_IF),
      .reg_IE               (reg_IE),
      .rdata_o              (rdata_o),
      .rdata_hit_o          (rdata_hit_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_val(input string tag, input logic [7:0] val);
      tag_q.push_back(tag);
      exp_q.push_back(val);
   endtask

   task automatic chk(input logic [7:0] obs);
      logic [7:0] e;
      string      t;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL scoreboard_empty observed=%02h", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", t, obs, e);
         end
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      addr_i  = a;
      data_i  = d;
      wr_en_i = 1'b1;
      tick(1);
      wr_en_i = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_interrupt_flag = 1'b1;
      tick(1);
      clear_interrupt_flag = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      addr_i  = 16'hFF0F;
      data_i  = 8'h00;
      wr_en_i = 1'b0;
      clear_interrupt_flag = 1'b0;
      irq_i   = 5'h1F;

      // Reset state with all requests high
      #12;
      expect_val("rst_if", 8'h00);      chk(reg_IF);
      expect_val("rst_ie", 8'h00);      chk(reg_IE);
      expect_val("rst_rd_if", 8'hE0);   chk(rdata_o);
      expect_val("rst_hit", 8'h01);     chk({7'd0, rdata_hit_o});
      irq_i = 5'h00;
      tick(1);
      reset_n = 1'b1;
      tick(LAT + 2);
      expect_val("post_rst_if", 8'h00); chk(reg_IF);

      // Edge detect on irq_i[2], held
      irq_i = 5'h04;
      tick(LAT - 1);
      expect_val("edge_early", 8'h00);  chk(reg_IF);
      tick(1);
      expect_val("edge_set", 8'h04);    chk(reg_IF);
      bus_write(16'hFF0F, 8'h00);
      expect_val("edge_wr0", 8'h00);    chk(reg_IF);
      tick(6);
      expect_val("edge_held", 8'h00);   chk(reg_IF);
      irq_i = 5'h00;
      tick(LAT + 1);
      irq_i = 5'h04;
      tick(LAT);
      expect_val("edge_rerise", 8'h04); chk(reg_IF);
      irq_i = 5'h00;
      tick(LAT + 1);

      // Priority clear
      bus_write(16'hFF0F, 8'h1A);
      bus_write(16'hFFFF, 8'h18);
      expect_val("pc_if_init", 8'h1A);  chk(reg_IF);
      expect_val("pc_ie_init", 8'h18);  chk(reg_IE);
      pulse_clear();
      expect_val("pc_clr1", 8'h12);     chk(reg_IF);
      pulse_clear();
      expect_val("pc_clr2", 8'h02);     chk(reg_IF);
      pulse_clear();
      expect_val("pc_clr_none", 8'h02); chk(reg_IF);
      addr_i = 16'hFF0F;
      #1;
      expect_val("pc_rd_if", 8'hE2);    chk(rdata_o);

      // Collision: clear vs rising bit 0
      bus_write(16'hFF0F, 8'h01);
      bus_write(16'hFFFF, 8'h01);
      irq_i = 5'h01;
      tick(LAT - 1);
      pulse_clear();
      expect_val("col_clr_rise", 8'h01); chk(reg_IF);
      pulse_clear();
      expect_val("col_clr_after", 8'h00); chk(reg_IF);
      irq_i = 5'h00;
      tick(LAT + 1);

      // Collision: write 0 vs rising bit 3
      irq_i = 5'h08;
      tick(LAT - 1);
      bus_write(16'hFF0F, 8'h00);
      expect_val("col_wr_rise", 8'h08); chk(reg_IF);
      irq_i = 5'h00;
      tick(LAT + 1);

      // Write beats clear; clear uses old IE when IE written same cycle
      bus_write(16'hFF0F, 8'h03);
      bus_write(16'hFFFF, 8'h03);
      addr_i = 16'hFF0F; data_i = 8'h04; wr_en_i = 1'b1; clear_interrupt_flag = 1'b1;
      tick(1);
      wr_en_i = 1'b0; clear_interrupt_flag = 1'b0;
      expect_val("wr_over_clr", 8'h04); chk(reg_IF);
      bus_write(16'hFF0F, 8'h03);
      bus_write(16'hFFFF, 8'h02);
      addr_i = 16'hFFFF; data_i = 8'h01; wr_en_i = 1'b1; clear_interrupt_flag = 1'b1;
      tick(1);
      wr_en_i = 1'b0; clear_interrupt_flag = 1'b0;
      expect_val("clr_old_ie_if", 8'h01); chk(reg_IF);
      expect_val("clr_old_ie_ie", 8'h01); chk(reg_IE);

      // Bus accesses
      bus_write(16'hFFFF, 8'hFF);
      expect_val("bus_reg_ie", 8'hFF);  chk(reg_IE);
      addr_i = 16'hFFFF;
      #1;
      expect_val("bus_rd_ie", 8'hFF);   chk(rdata_o);
      bus_write(16'hFF0F, 8'hFF);
      expect_val("bus_reg_if", 8'h1F);  chk(reg_IF);
      addr_i = 16'hFF0F;
      #1;
      expect_val("bus_rd_if", 8'hFF);   chk(rdata_o);
      expect_val("bus_hit_if", 8'h01);  chk({7'd0, rdata_hit_o});
      wr_en_i = 1'b1; data_i = 8'h00; addr_i = 16'hFF10;
      #1;
      expect_val("bus_hit_wr", 8'h00);  chk({7'd0, rdata_hit_o});
      wr_en_i = 1'b0;
      #1;
      expect_val("bus_hit_miss", 8'h00); chk({7'd0, rdata_hit_o});
      expect_val("bus_rd_miss", 8'h00); chk(rdata_o);
      bus_write(16'hFF10, 8'h00);
      expect_val("bus_miss_wr_if", 8'h1F); chk(reg_IF);

      // Async reset mid-cycle, requests already high on release
      bus_write(16'hFFFF, 8'h1F);
      addr_i = 16'hFF0F;
      irq_i = 5'h10;
      #2;
      reset_n = 1'b0;
      #1;
      expect_val("arst_if", 8'h00);     chk(reg_IF);
      expect_val("arst_ie", 8'h00);     chk(reg_IE);
      expect_val("arst_rd", 8'hE0);     chk(rdata_o);
      #3;
      reset_n = 1'b1;
      tick(LAT);
      expect_val("arst_rise", 8'h10);   chk(reg_IF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
